// File: rtl/bram_write_window_if.sv
// Address-in / write-window-out bundle between the BRAM address counter,
// the write-window generator and the BRAM write port.
interface bram_write_window_if #(
  parameter int BRAM_WIDTH = 10
);
  logic [BRAM_WIDTH-1:0] address;
  logic                  wen;
  logic [BRAM_WIDTH-1:0] count;
  logic                  init;

  modport master (output address, input wen, input count, input init);
  modport slave  (input address, output wen, output count, output init);
endinterface

// File: rtl/bram_write_window.sv
// Write-enable generator for one address-aligned BRAM capture sweep:
// arm on restart, wait for the last address, then write 2**BRAM_WIDTH cycles.
module bram_write_window #(
  parameter int BRAM_WIDTH = 10
) (
  input  logic               clk,
  input  logic               restart,
  bram_write_window_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WRITING
  } state_t;

  localparam logic [BRAM_WIDTH-1:0] LAST = '1;

  state_t                r_state = S_IDLE;
  logic                  r_wen   = 1'b0;
  logic [BRAM_WIDTH-1:0] r_count = '0;
  logic                  r_init  = 1'b0;

  state_t                w_state;
  logic                  w_wen;
  logic [BRAM_WIDTH-1:0] w_count;
  logic                  w_init;

  always_ff @(posedge clk) begin
    r_state <= w_state;
    r_wen   <= w_wen;
    r_count <= w_count;
    r_init  <= w_init;
  end

  // Next-state decode; every output is the registered image of this decode
  always_comb begin
    w_state = r_state;
    w_wen   = 1'b0;
    w_count = '0;
    w_init  = 1'b0;
    if (restart) begin
      w_state = S_ARMED;
      w_init  = 1'b1;
    end else begin
      unique case (r_state)
        S_ARMED: begin
          if (bus.address == LAST) begin
            w_state = S_WRITING;
            w_wen   = 1'b1;
          end else begin
            w_init  = 1'b1;
          end
        end
        S_WRITING: begin
          // Address is no longer consulted: the sweep length is set by count alone
          if (r_count == LAST) begin
            w_state = S_IDLE;
          end else begin
            w_wen   = 1'b1;
            w_count = r_count + 1'b1;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  assign bus.wen   = r_wen;
  assign bus.count = r_count;
  assign bus.init  = r_init;

endmodule

// File: tb/tb_bram_write_window.sv
// Randomised and directed bench for bram_write_window at BRAM_WIDTH=5,
// compared cycle by cycle against a sweep-index reference model.
module tb_bram_write_window;
  localparam int W    = 5;
  localparam int SIZE = 1 << W;

  logic clk = 1'b0;
  logic restart = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bram_write_window_if #(.BRAM_WIDTH(W)) bus ();

  bram_write_window #(.BRAM_WIDTH(W)) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: armed flag plus position within the current sweep (-1 = none)
  bit         m_armed = 1'b0;
  int         m_idx   = -1;
  logic       e_wen;
  logic [W-1:0] e_cnt;
  logic       e_init;

  task automatic drive(input logic r, input int a);
    restart     = r;
    bus.address = a[W-1:0];
    @(posedge clk);
    if (r) begin
      m_armed = 1'b1;
      m_idx   = -1;
    end else if (m_armed && a == SIZE - 1) begin
      m_armed = 1'b0;
      m_idx   = 0;
    end else if (m_idx >= 0) begin
      m_idx = m_idx + 1;
      if (m_idx == SIZE) m_idx = -1;
    end
    e_wen  = (m_idx >= 0);
    e_cnt  = (m_idx >= 0) ? m_idx[W-1:0] : '0;
    e_init = m_armed;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.wen, bus.count, bus.init} !== {1'b0, {W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL powerup: wen=%b count=%0d init=%b required 0/0/0", bus.wen, bus.count, bus.init);
    end
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 6);
      checks++;
      if ({bus.wen, bus.count, bus.init} !== {e_wen, e_cnt, e_init}) begin
        errors++;
        $display("FAIL idle_hold[%0d]: wen=%b count=%0d init=%b required %b/%0d/%b",
                 i, bus.wen, bus.count, bus.init, e_wen, e_cnt, e_init);
      end
    end
  endtask

  task automatic test_arm();
    drive(1'b1, 6);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive(1'b0, 6);
      checks++;
      if ({bus.wen, bus.count, bus.init} !== {1'b0, {W{1'b0}}, 1'b1}) begin
        errors++;
        $display("FAIL arm[%0d]: wen=%b count=%0d init=%b required 0/0/1",
                 i, bus.wen, bus.count, bus.init);
      end
    end
  endtask

  task automatic test_alignment();
    int wen_cycles = 0;
    drive(1'b0, SIZE - 1);
    for (int i = 0; i < SIZE + 62; i++) begin
      if (i > 0) drive(1'b0, 0);
      if (bus.wen === 1'b1) wen_cycles++;
      checks++;
      if (i < SIZE) begin
        if ({bus.wen, bus.count, bus.init} !== {1'b1, i[W-1:0], 1'b0}) begin
          errors++;
          $display("FAIL align[%0d]: wen=%b count=%0d init=%b required 1/%0d/0",
                   i, bus.wen, bus.count, bus.init, i);
        end
      end else if ({bus.wen, bus.count, bus.init} !== {1'b0, {W{1'b0}}, 1'b0}) begin
        errors++;
        $display("FAIL after_sweep[%0d]: wen=%b count=%0d init=%b required 0/0/0",
                 i, bus.wen, bus.count, bus.init);
      end
    end
    checks++;
    if (wen_cycles != SIZE) begin
      errors++;
      $display("FAIL sweep_len: got %0d required %0d", wen_cycles, SIZE);
    end
  endtask

  task automatic test_abort();
    int wen_cycles = 0;
    drive(1'b1, 3);
    drive(1'b0, SIZE - 1);
    while (bus.count !== 5'd10 && wen_cycles < 2 * SIZE) begin
      drive(1'b0, $urandom_range(0, SIZE - 2));
      wen_cycles++;
    end
    checks++;
    if (bus.count !== 5'd10 || bus.wen !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach: count=%0d wen=%b required 10/1", bus.count, bus.wen);
    end
    drive(1'b1, SIZE - 1);
    checks++;
    if ({bus.wen, bus.count, bus.init} !== {1'b0, {W{1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL abort: wen=%b count=%0d init=%b required 0/0/1", bus.wen, bus.count, bus.init);
    end
    drive(1'b0, SIZE - 1);
    wen_cycles = 0;
    for (int i = 0; i < SIZE + 8; i++) begin
      if (i > 0) drive(1'b0, $urandom_range(0, SIZE - 1));
      if (bus.wen === 1'b1) wen_cycles++;
      checks++;
      if ({bus.wen, bus.count, bus.init} !== {e_wen, e_cnt, e_init}) begin
        errors++;
        $display("FAIL retrigger[%0d]: wen=%b count=%0d init=%b required %b/%0d/%b",
                 i, bus.wen, bus.count, bus.init, e_wen, e_cnt, e_init);
      end
    end
    checks++;
    if (wen_cycles != SIZE) begin
      errors++;
      $display("FAIL retrigger_len: got %0d required %0d", wen_cycles, SIZE);
    end
  endtask

  task automatic test_restart_align();
    for (int i = 0; i < 3; i++) drive(1'b1, SIZE - 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, i + 2);
      checks++;
      if ({bus.wen, bus.count, bus.init} !== {1'b0, {W{1'b0}}, 1'b1}) begin
        errors++;
        $display("FAIL restart_align[%0d]: wen=%b count=%0d init=%b required 0/0/1",
                 i, bus.wen, bus.count, bus.init);
      end
    end
    drive(1'b0, SIZE - 1);
    drive(1'b0, 0);
    checks++;
    if ({bus.wen, bus.count, bus.init} !== {1'b1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL restart_align_start: wen=%b count=%0d init=%b required 1/1/0",
               bus.wen, bus.count, bus.init);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      logic r;
      int   a;
      r = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 7) == 0) ? SIZE - 1 : int'($urandom_range(0, SIZE - 1));
      drive(r, a);
      checks++;
      if ({bus.wen, bus.count, bus.init} !== {e_wen, e_cnt, e_init}) begin
        errors++;
        $display("FAIL random[%0d]: wen=%b count=%0d init=%b required %b/%0d/%b",
                 i, bus.wen, bus.count, bus.init, e_wen, e_cnt, e_init);
      end
    end
  endtask

  initial begin
    bus.address = '0;
    test_reset();
    test_idle_hold();
    test_arm();
    test_alignment();
    test_abort();
    test_restart_align();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
